// File: rtl/key_queue.sv
// Circular keypoint FIFO with show-ahead head, flush and optional score filter.
// Optional feature: define KEY_QUEUE_SCORE_FILTER_EN to drop inputs scoring below i_score_th.
module key_queue #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 10,
    parameter int unsigned SCORE_W = 8,
    parameter int unsigned DESC_W  = 256
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_flush,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [X_W-1:0]                 i_coor_x,
    input  logic [Y_W-1:0]                 i_coor_y,
    input  logic [SCORE_W-1:0]             i_score,
    input  logic [DESC_W-1:0]              i_descriptor,
    input  logic [SCORE_W-1:0]             i_score_th,
    output logic                           o_valid,
    input  logic                           i_next,
    output logic [X_W-1:0]                 o_coor_x,
    output logic [Y_W-1:0]                 o_coor_y,
    output logic [SCORE_W-1:0]             o_score,
    output logic [DESC_W-1:0]              o_descriptor,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic [15:0]                    o_drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = X_W + Y_W + SCORE_W + DESC_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             push_c, pop_c, drop_c;
    logic [ENT_W-1:0] head_c;

`ifdef KEY_QUEUE_SCORE_FILTER_EN
    assign drop_c = i_valid && o_ready && (i_score < i_score_th);
`else
    logic unused_score_th;
    assign unused_score_th = ^i_score_th;
    assign drop_c          = 1'b0;
`endif

    assign o_ready    = (count_q != FULL_CNT);
    assign o_valid    = (count_q != '0);
    assign o_count    = count_q;
    assign o_drop_cnt = drop_cnt_q;
    assign push_c     = i_valid && o_ready && !drop_c;
    assign pop_c      = o_valid && i_next;

    // Show-ahead head; fields forced to zero while empty.
    assign head_c = o_valid ? mem_q[rd_ptr_q] : '0;
    assign {o_coor_x, o_coor_y, o_score, o_descriptor} = head_c;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CNT_W'(1);
            end
            if (drop_c && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (push_c && !i_flush && !i_rst) begin
            mem_q[wr_ptr_q] <= {i_coor_x, i_coor_y, i_score, i_descriptor};
        end
    end

endmodule

// File: doc/key_queue.md
KEY_QUEUE -- requirements
Module: key_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 128, number of keypoint entries (2..1024, any integer, not restricted to powers of two).
REQ-002 SHALL have parameter X_W, default 10, x-coordinate width.
REQ-003 SHALL have parameter Y_W, default 10, y-coordinate width.
REQ-004 SHALL have parameter SCORE_W, default 8, score width.
REQ-005 SHALL have parameter DESC_W, default 256, descriptor width.
REQ-006 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port i_flush, input, 1, synchronous clear of stored entries.
REQ-009 SHALL have port i_valid, input, 1, input keypoint present.
REQ-010 SHALL have port o_ready, output, 1, queue can accept the input keypoint.
REQ-011 SHALL have ports i_coor_x / i_coor_y / i_score / i_descriptor, input, X_W / Y_W / SCORE_W / DESC_W, input keypoint fields.
REQ-012 SHALL have port i_score_th, input, SCORE_W, score threshold (used only per REQ-031).
REQ-013 SHALL have port o_valid, output, 1, head entry present.
REQ-014 SHALL have port i_next, input, 1, consumer takes the head entry.
REQ-015 SHALL have ports o_coor_x / o_coor_y / o_score / o_descriptor, output, X_W / Y_W / SCORE_W / DESC_W, head entry fields.
REQ-016 SHALL have port o_count, output, clog2(DEPTH+1), number of stored entries.
REQ-017 SHALL have port o_drop_cnt, output, 16, count of filtered-out inputs.

Function
REQ-018 SHALL be a circular FIFO: register-array storage, write pointer, read pointer, occupancy counter.
REQ-019 Push SHALL occur when i_valid && o_ready and the input is not filtered; the entry is written at the write pointer, the write pointer advances and the count increments.
REQ-020 o_ready SHALL equal (o_count != DEPTH), be registered-state-derived only and have no combinational path from i_next or i_valid.
REQ-021 o_valid SHALL equal (o_count != 0); the o_* head fields SHALL show the entry at the read pointer with no added latency (show-ahead).
REQ-022 Pop SHALL occur when o_valid && i_next; the read pointer advances and the count decrements. i_next while o_valid is 0 SHALL be ignored.
REQ-023 Latency SHALL be one cycle: an entry pushed in cycle N is visible on o_* with o_valid=1 in cycle N+1 when the queue was empty.
REQ-024 Simultaneous push and pop SHALL leave the count unchanged and advance both pointers.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH value.
REQ-026 When full, i_valid SHALL be back-pressured through o_ready=0; no entry SHALL be overwritten or lost, including when a pop occurs in the same cycle.
REQ-027 While o_valid is 0, the o_* head fields SHALL be all zero.
REQ-028 i_flush SHALL set both pointers and the count to 0 on the next edge and take priority over push and pop in the same cycle. Storage contents need not be cleared. o_drop_cnt SHALL be preserved.
REQ-029 Entries SHALL leave in arrival order; the field values SHALL be bit-exact to the input.

Reset
REQ-030 On i_rst=1 at a rising edge: pointers=0, o_count=0, o_valid=0, o_ready=1, o_* head fields=0, o_drop_cnt=0. Reset SHALL override flush, push and pop, including mid-burst.

Configuration
REQ-031 With macro KEY_QUEUE_SCORE_FILTER_EN defined:
- an input with i_valid && o_ready && i_score < i_score_th SHALL be consumed but not stored;
- o_drop_cnt SHALL increment per such input and saturate at 16'hFFFF.
Without the macro:
- i_score_th SHALL be ignored and every handshaken input SHALL be stored;
- o_drop_cnt SHALL be constant 0.

Verification (DEPTH=4, SCORE_W=8)
REQ-032 Reset, then push x=1,2,3 on consecutive cycles -> o_count reaches 3; o_coor_x=1 the cycle after the first push; popping yields 1,2,3 in order.
REQ-033 Push 4 entries with i_next=0 -> o_count=4, o_ready=0; a fifth i_valid is held, not stored; after one pop, o_ready=1 and the fifth entry is accepted.
REQ-034 Queue holds 2 entries; assert push and pop in the same cycle for 6 cycles -> o_count stays 2; pointers wrap; output order is preserved.
REQ-035 With 3 entries stored, assert i_flush together with i_valid and i_next -> next cycle o_count=0, o_valid=0, o_* fields=0, o_ready=1.
REQ-036 Macro defined, i_score_th=50: push scores 10, 60, 50, 49 -> only 60 and 50 are stored and o_drop_cnt=2. Macro undefined, same stimulus: all 4 are stored and o_drop_cnt=0.
REQ-037 Assert i_rst mid-burst with 3 entries stored and i_valid=1 -> next cycle all outputs are at their reset values and no entry is stored.
